branch_target_predictor: RTL

Parametrised branch target buffer with saturating-counter direction prediction for the pipelined RV32I core. It sits beside instruction fetch and predicts the next PC for the fetched address. It is trained by resolved control-flow instructions leaving MEM. The pipeline flushes only on a misprediction, instead of on every taken branch/JAL/JALR.

---
 rtl/branch_target_predictor_pkg.sv | 47 ++++
 rtl/branch_target_predictor_if.sv | 42 ++++
 rtl/branch_target_predictor_table.sv | 90 +++++++++
 rtl/branch_target_predictor.sv | 103 ++++++++++
 4 files changed

// File: rtl/branch_target_predictor_pkg.sv
// Shared types and helpers for the branch target predictor.
//
// BtbEntry  : one table entry as seen through the table read port. The fields
//             are sized for the widest supported configuration, and narrower
//             fields are zero-extended into them.
// BtbUpdate : the resolved control-flow bundle (upd_*). The core carries it in
//             the EX/MEM register.
// saturating_step : moves a direction counter one step up or down. The counter
//             sticks at 0 and at its all-ones value.
package branch_target_predictor_pkg;

    localparam int BTB_ADDR_W    = 32;
    localparam int BTB_MAX_CTR_W = 4;

    typedef struct packed {
        logic                     valid;
        logic [BTB_ADDR_W-1:0]    tag;
        logic [BTB_ADDR_W-1:0]    target;
        logic [BTB_MAX_CTR_W-1:0] ctr;
    } BtbEntry;

    typedef struct packed {
        logic                  valid;
        logic [BTB_ADDR_W-1:0] pc;
        logic                  taken;
        logic [BTB_ADDR_W-1:0] target;
        logic                  pred_taken;
        logic [BTB_ADDR_W-1:0] pred_target;
    } BtbUpdate;

    // width is the live counter width (1..BTB_MAX_CTR_W). Bits above it are
    // expected to be zero on entry and stay zero on exit.
    function automatic logic [BTB_MAX_CTR_W-1:0] saturating_step(
        input logic [BTB_MAX_CTR_W-1:0] ctr,
        input logic                     up,
        input int unsigned              width
    );
        logic [BTB_MAX_CTR_W-1:0] maxVal;
        maxVal = BTB_MAX_CTR_W'((5'd1 << width) - 5'd1);
        if (up) begin
            saturating_step = (ctr == maxVal) ? ctr : ctr + 1'b1;
        end else begin
            saturating_step = (ctr == '0) ? ctr : ctr - 1'b1;
        end
    endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// Bus between the fetch/MEM side of the core (master) and the predictor
// (slave).
//
// Lookup  : lookup_pc and lookup_en in; pred_taken and pred_target out.
// Update  : upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
//           upd_pred_target and invalidate in; mispredict out.
// Perf    : perf_lookups and perf_mispredicts out.
interface branch_target_predictor_if #(
    parameter int ADDR_W = 32,
    parameter int PERF_W = 32
) ();

    logic              lookup_en;
    logic [ADDR_W-1:0] lookup_pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;

    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_pred_taken;
    logic [ADDR_W-1:0] upd_pred_target;
    logic              invalidate;
    logic              mispredict;

    logic [PERF_W-1:0] perf_lookups;
    logic [PERF_W-1:0] perf_mispredicts;

    modport master (
        output lookup_en, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target, invalidate,
        input  pred_taken, pred_target, mispredict, perf_lookups, perf_mispredicts
    );

    modport slave (
        input  lookup_en, lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target, invalidate,
        output pred_taken, pred_target, mispredict, perf_lookups, perf_mispredicts
    );

endinterface

// File: rtl/branch_target_predictor_table.sv
// BTB storage: an ENTRIES-deep register array.
//
// Ports
//   clk, reset     : clock; asynchronous active-high reset that clears every field.
//   i_rdIdx        : index of the asynchronous lookup read port.
//   o_rdEntry      : entry at i_rdIdx, with fields zero-extended into BtbEntry.
//   i_upd*         : read-modify-write update port. Hit/miss at i_updIdx is
//                    decided here, and the result is written on the clock edge.
//   i_invalidate   : clears every valid bit in one cycle. It wins over an update.
module btb_table
    import branch_target_predictor_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int CTR_W   = 2,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = ADDR_W - 2 - IDX_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  i_rdIdx,
    output BtbEntry           o_rdEntry,
    input  logic              i_updValid,
    input  logic [IDX_W-1:0]  i_updIdx,
    input  logic [TAG_W-1:0]  i_updTag,
    input  logic              i_updTaken,
    input  logic [ADDR_W-1:0] i_updTarget,
    input  logic              i_invalidate
);

    // The valid bits are kept as a flat vector of flops so that invalidate can
    // clear all of them in one edge.
    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];
    logic [CTR_W-1:0]   r_ctr    [ENTRIES];

    logic                     w_updHit;
    logic [BTB_MAX_CTR_W-1:0] w_stepped;
    logic [CTR_W-1:0]         w_nextCtr;
    logic                     w_unusedStep;

    // Lookup read port: purely combinational from the registered state, so a
    // same-cycle update is not bypassed.
    always_comb begin
        o_rdEntry        = '0;
        o_rdEntry.valid  = r_valid[i_rdIdx];
        o_rdEntry.tag    = BTB_ADDR_W'(r_tag[i_rdIdx]);
        o_rdEntry.target = BTB_ADDR_W'(r_target[i_rdIdx]);
        o_rdEntry.ctr    = BTB_MAX_CTR_W'(r_ctr[i_rdIdx]);
    end

    assign w_updHit     = r_valid[i_updIdx] && (r_tag[i_updIdx] == i_updTag);
    assign w_stepped    = saturating_step(BTB_MAX_CTR_W'(r_ctr[i_updIdx]), i_updTaken, CTR_W);
    assign w_nextCtr    = CTR_W'(w_stepped);
    assign w_unusedStep = (w_stepped >> CTR_W) != '0;

    // Training rules:
    //   hit             : the counter steps toward the outcome, and a taken
    //                     outcome also refreshes the target.
    //   miss, taken     : the entry is replaced and starts weakly taken.
    //   miss, not taken : nothing changes.
    // Invalidate only drops the valid bits and leaves counters and targets as
    // they are.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= '0;
            end
        end else if (i_invalidate) begin
            r_valid <= '0;
        end else if (i_updValid) begin
            if (w_updHit) begin
                r_ctr[i_updIdx] <= w_nextCtr;
                if (i_updTaken) begin
                    r_target[i_updIdx] <= i_updTarget;
                end
            end else if (i_updTaken) begin
                r_valid[i_updIdx]  <= 1'b1;
                r_tag[i_updIdx]    <= i_updTag;
                r_target[i_updIdx] <= i_updTarget;
                r_ctr[i_updIdx]    <= CTR_W'(1 << (CTR_W - 1));
            end
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Branch target buffer with saturating-counter direction prediction. It sits
// beside instruction fetch and is trained by control-flow instructions as they
// resolve and leave MEM.
//
// Ports
//   clk, reset : clock; asynchronous active-high reset.
//   bus        : branch_target_predictor_if slave. It carries the lookup,
//                update, invalidate, mispredict and perf signals.
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int CTR_W   = 2,
    parameter int PERF_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    branch_target_predictor_if.slave  bus
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    BtbEntry           w_rdEntry;
    BtbUpdate          w_upd;
    logic              w_hit;
    logic              w_ctrMsb;
    logic              w_predTaken;
    logic              w_mispredict;
    logic              w_unusedPcBits;
    logic [PERF_W-1:0] r_perfLookups;
    logic [PERF_W-1:0] r_perfMispredicts;

    always_comb begin
        w_upd             = '0;
        w_upd.valid       = bus.upd_valid;
        w_upd.pc          = BTB_ADDR_W'(bus.upd_pc);
        w_upd.taken       = bus.upd_taken;
        w_upd.target      = BTB_ADDR_W'(bus.upd_target);
        w_upd.pred_taken  = bus.upd_pred_taken;
        w_upd.pred_target = BTB_ADDR_W'(bus.upd_pred_target);
    end

    // PC[1:0] never selects or tags an entry.
    assign w_unusedPcBits = ^{bus.lookup_pc[1:0], w_upd.pc[1:0]};

    btb_table #(
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W),
        .CTR_W   (CTR_W),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_table (
        .clk          (clk),
        .reset        (reset),
        .i_rdIdx      (bus.lookup_pc[IDX_W+1:2]),
        .o_rdEntry    (w_rdEntry),
        .i_updValid   (w_upd.valid),
        .i_updIdx     (w_upd.pc[IDX_W+1:2]),
        .i_updTag     (w_upd.pc[ADDR_W-1:IDX_W+2]),
        .i_updTaken   (w_upd.taken),
        .i_updTarget  (w_upd.target[ADDR_W-1:0]),
        .i_invalidate (bus.invalidate)
    );

    // The table zero-extends its fields, so comparing and testing the full
    // widths is the same as comparing and testing the live bits.
    assign w_hit       = w_rdEntry.valid &&
                         (w_rdEntry.tag == BTB_ADDR_W'(bus.lookup_pc[ADDR_W-1:IDX_W+2]));
    assign w_ctrMsb    = (w_rdEntry.ctr >> (CTR_W - 1)) != '0;
    assign w_predTaken = w_hit && w_ctrMsb;

    assign bus.pred_taken  = w_predTaken;
    assign bus.pred_target = w_predTaken ? ADDR_W'(w_rdEntry.target) : '0;

    // A wrong direction is always a mispredict. A wrong target matters only
    // when the instruction really redirected.
    assign w_mispredict = w_upd.valid &&
                          ((w_upd.pred_taken != w_upd.taken) ||
                           (w_upd.taken && (w_upd.pred_target != w_upd.target)));
    assign bus.mispredict = w_mispredict;

    // Perf counters stick at all-ones instead of wrapping. Invalidate leaves
    // them alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perfLookups     <= '0;
            r_perfMispredicts <= '0;
        end else begin
            if (bus.lookup_en && (r_perfLookups != '1)) begin
                r_perfLookups <= r_perfLookups + 1'b1;
            end
            if (w_mispredict && (r_perfMispredicts != '1)) begin
                r_perfMispredicts <= r_perfMispredicts + 1'b1;
            end
        end
    end

    assign bus.perf_lookups     = r_perfLookups;
    assign bus.perf_mispredicts = r_perfMispredicts;

endmodule
